// File: rtl/glyph_pixel_streamer_pkg.sv
// Shared constants, state type and bitmap indexing for the glyph pixel streamer.
package glyph_pkg;

    localparam int GLYPH_W    = 5;
    localparam int GLYPH_H    = 7;
    localparam int GLYPH_BITS = 35;
    localparam int CHAR_MIN   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } glyph_state_t;

    // Bit 34 is the top-left pixel, bit 0 is row 6 / col 4.
    function automatic logic [5:0] bit_index(input logic [2:0] row, input logic [2:0] col);
        return 6'(GLYPH_BITS - 1 - (int'(row) * GLYPH_W + int'(col)));
    endfunction

endpackage

// File: rtl/glyph_pixel_streamer_if.sv
// Handshake bundles: character input (valid/ready/code) and pixel output stream.
interface glyph_char_if;
    logic       valid;
    logic       ready;
    logic [7:0] code;

    modport master (output valid, output code, input ready);
    modport slave  (input valid, input code, output ready);
endinterface

interface glyph_pix_if;
    logic       valid;
    logic       ready;
    logic       on;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;

    modport master (output valid, output on, output row, output col, output last, input ready);
    modport slave  (input valid, input on, input row, input col, input last, output ready);
endinterface

// File: rtl/glyph_pixel_streamer_scan.sv
// Row/column scan position for one glyph: column-major, optional serpentine rows.
module glyph_scan_counter
    import glyph_pkg::*;
#(
    parameter int SPACER_COLS = 1,
    parameter bit SERPENTINE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       step_i,
    output logic [2:0] row_o,
    output logic [2:0] col_o,
    output logic       last_o
);

    localparam logic [2:0] LAST_COL = 3'(GLYPH_W - 1 + SPACER_COLS);
    localparam logic [2:0] ROW_MAX  = 3'(GLYPH_H - 1);

    if (SPACER_COLS < 0 || SPACER_COLS > 2) begin : g_bad_spacer
        $error("SPACER_COLS must be 0..2");
    end

    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       up_scan;
    logic       col_done;

    always_comb begin
        up_scan  = SERPENTINE && col_q[0];
        col_done = up_scan ? (row_q == 3'd0) : (row_q == ROW_MAX);
        last_o   = col_done && (col_q == LAST_COL);
        row_d    = row_q;
        col_d    = col_q;
        if (load_i) begin
            row_d = 3'd0;
            col_d = 3'd0;
        end else if (step_i && !last_o) begin
            if (col_done) begin
                // next column starts at the far end when its direction flips
                col_d = col_q + 3'd1;
                row_d = (SERPENTINE && !col_q[0]) ? ROW_MAX : 3'd0;
            end else begin
                row_d = up_scan ? row_q - 3'd1 : row_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= 3'd0;
            col_q <= 3'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/glyph_pixel_streamer.sv
// Character ROM reader: accepts ASCII bytes, latches the 5x7 bitmap and streams pixels.
//
// state | meaning
// IDLE  | waiting for a character, char_ready high
// FETCH | rom_addr valid, bitmap captured from rom_data this cycle
// EMIT  | presenting pixels, advancing on each pixel handshake
module glyph_pixel_streamer
    import glyph_pkg::*;
#(
    parameter int         SPACER_COLS = 1,
    parameter bit         SERPENTINE  = 1'b1,
    parameter logic [7:0] SUBST_CHAR  = 8'h3F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    glyph_char_if.slave        char_if,
    output logic [6:0]         rom_addr_o,
    input  logic [GLYPH_BITS-1:0] rom_data_i,
    glyph_pix_if.master        pix_if,
    output logic               busy_o
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_EMIT  = EMIT;

    logic [1:0]            state_q, state_d;
    logic [GLYPH_BITS-1:0] bitmap_q, bitmap_d;
    logic [6:0]            rom_addr_q, rom_addr_d;
    logic [2:0]            row;
    logic [2:0]            col;
    logic                  last_pix;
    logic                  is_emit;
    logic                  pix_hs;
    logic                  char_acc;

    assign is_emit  = (state_q == S_EMIT);
    assign pix_hs   = is_emit && pix_if.ready;
    // The last pixel handshake can hand straight over to the next character.
    assign char_if.ready = !clear_i && ((state_q == S_IDLE) || (pix_hs && last_pix));
    assign char_acc = char_if.valid && char_if.ready;

    always_comb begin
        state_d    = state_q;
        bitmap_d   = bitmap_q;
        rom_addr_d = rom_addr_q;
        if (char_acc) begin
            rom_addr_d = char_if.code[7] ? SUBST_CHAR[6:0] : char_if.code[6:0];
        end
        if (state_q == S_FETCH) begin
            bitmap_d = rom_data_i;
        end
        case (state_q)
            S_IDLE:  if (char_acc) state_d = S_FETCH;
            S_FETCH: state_d = S_EMIT;
            S_EMIT:  if (pix_hs && last_pix) state_d = char_acc ? S_FETCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bitmap_q   <= '0;
            rom_addr_q <= 7'd0;
        end else begin
            state_q    <= state_d;
            bitmap_q   <= bitmap_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    glyph_scan_counter #(
        .SPACER_COLS (SPACER_COLS),
        .SERPENTINE  (SERPENTINE)
    ) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (state_q == S_FETCH),
        .step_i (pix_hs && !clear_i),
        .row_o  (row),
        .col_o  (col),
        .last_o (last_pix)
    );

    assign pix_if.valid = is_emit;
    assign pix_if.on    = (col < 3'(GLYPH_W)) ? bitmap_q[bit_index(row, col)] : 1'b0;
    assign pix_if.row   = row;
    assign pix_if.col   = col;
    assign pix_if.last  = is_emit && last_pix;
    assign rom_addr_o   = rom_addr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_glyph_pixel_streamer.sv
// Bench: two streamer instances (serpentine/1 spacer, straight/2 spacers) against a pixel-list model.
module tb_glyph_pixel_streamer;

    localparam int SP0 = 1;
    localparam int SP1 = 2;
    localparam bit SE0 = 1'b1;
    localparam bit SE1 = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        cv = 1'b0;
    logic [7:0]  code = 8'h00;
    logic        pr = 1'b1;
    logic [34:0] rom [128];

    glyph_char_if cif0 ();
    glyph_char_if cif1 ();
    glyph_pix_if  pif0 ();
    glyph_pix_if  pif1 ();

    logic [6:0]  rom_addr0, rom_addr1;
    logic [34:0] rom_data0, rom_data1;
    logic        busy0, busy1;

    assign cif0.valid = cv;
    assign cif1.valid = cv;
    assign cif0.code  = code;
    assign cif1.code  = code;
    assign pif0.ready = pr;
    assign pif1.ready = pr;
    assign rom_data0  = rom[rom_addr0];
    assign rom_data1  = rom[rom_addr1];

    glyph_pixel_streamer #(.SPACER_COLS(SP0), .SERPENTINE(SE0), .SUBST_CHAR(8'h3F)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .char_if(cif0),
        .rom_addr_o(rom_addr0), .rom_data_i(rom_data0), .pix_if(pif0), .busy_o(busy0));

    glyph_pixel_streamer #(.SPACER_COLS(SP1), .SERPENTINE(SE1), .SUBST_CHAR(8'h3F)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear), .char_if(cif1),
        .rom_addr_o(rom_addr1), .rom_data_i(rom_data1), .pix_if(pif1), .busy_o(busy1));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int hs [2] = '{0, 0};
    int m_phase [2] = '{0, 0};   // 0 idle, 1 waiting for bitmap, 2 streaming
    int m_idx [2] = '{0, 0};
    logic [6:0] m_addr [2] = '{7'd0, 7'd0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int n_of(input int i);
        return 7 * (5 + ((i == 0) ? SP0 : SP1));
    endfunction

    // k-th pixel of a glyph straight from the scan rules
    task automatic get_pix(input int i, input int k, input logic [6:0] a,
                           output logic [2:0] r, output logic [2:0] c, output logic on);
        int cc, rr;
        bit serp;
        serp = (i == 0) ? SE0 : SE1;
        cc = k / 7;
        rr = k % 7;
        if (serp && (cc % 2 == 1)) rr = 6 - rr;
        r  = 3'(rr);
        c  = 3'(cc);
        on = (cc < 5) ? rom[a][34 - (rr * 5 + cc)] : 1'b0;
    endtask

    task automatic model_step(input int i, input logic a_ready, input logic a_valid,
                              input logic a_on, input logic [2:0] a_row, input logic [2:0] a_col,
                              input logic a_last, input logic [6:0] a_addr, input logic a_busy);
        logic       e_ready, acc;
        logic [2:0] er, ec;
        logic       eon;
        int         n;
        string      p;
        p = $sformatf("u%0d", i);
        n = n_of(i);
        if (!rst_n) begin
            chk({p, ".rst_ready"}, a_ready, 1);
            chk({p, ".rst_valid"}, a_valid, 0);
            chk({p, ".rst_on"}, a_on, 0);
            chk({p, ".rst_row"}, a_row, 0);
            chk({p, ".rst_col"}, a_col, 0);
            chk({p, ".rst_last"}, a_last, 0);
            chk({p, ".rst_addr"}, a_addr, 0);
            chk({p, ".rst_busy"}, a_busy, 0);
            m_phase[i] = 0;
            m_idx[i]   = 0;
            m_addr[i]  = 7'd0;
            return;
        end
        e_ready = !clear && (m_phase[i] == 0 || (m_phase[i] == 2 && pr && m_idx[i] == n - 1));
        chk({p, ".char_ready"}, a_ready, e_ready);
        chk({p, ".pix_valid"}, a_valid, m_phase[i] == 2);
        chk({p, ".busy"}, a_busy, m_phase[i] != 0);
        chk({p, ".rom_addr"}, a_addr, m_addr[i]);
        if (m_phase[i] == 2) begin
            get_pix(i, m_idx[i], m_addr[i], er, ec, eon);
            chk({p, ".pix_row"}, a_row, er);
            chk({p, ".pix_col"}, a_col, ec);
            chk({p, ".pix_on"}, a_on, eon);
            chk({p, ".pix_last"}, a_last, m_idx[i] == n - 1);
            if (pr) hs[i]++;
        end
        acc = cv && e_ready;
        if (clear) begin
            m_phase[i] = 0;
        end else begin
            case (m_phase[i])
                0: if (acc) begin
                    m_phase[i] = 1;
                    m_addr[i]  = code[7] ? 7'h3F : code[6:0];
                end
                1: begin
                    m_phase[i] = 2;
                    m_idx[i]   = 0;
                end
                default: if (pr) begin
                    if (m_idx[i] == n - 1) begin
                        m_phase[i] = acc ? 1 : 0;
                        if (acc) m_addr[i] = code[7] ? 7'h3F : code[6:0];
                    end else begin
                        m_idx[i]++;
                    end
                end
            endcase
        end
    endtask

    always @(negedge clk) begin
        model_step(0, cif0.ready, pif0.valid, pif0.on, pif0.row, pif0.col, pif0.last, rom_addr0, busy0);
        model_step(1, cif1.ready, pif1.valid, pif1.on, pif1.row, pif1.col, pif1.last, rom_addr1, busy1);
    end

    task automatic wait_idle(input int budget, input string nm);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (m_phase[0] == 0 && m_phase[1] == 0) break;
        end
        if (k == budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout after %0d cycles, required idle", nm, budget);
        end
    endtask

    task automatic wait_ready0(input int budget, input string nm);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (cif0.ready) break;
        end
        if (k == budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: timeout after %0d cycles, required char_ready", nm, budget);
        end
    endtask

    initial begin
        logic [63:0] t;
        logic [2:0]  r, c;
        logic        on;
        int          ones, h0, h1, k;

        for (int i = 0; i < 128; i++) begin
            t = {$urandom, $urandom};
            rom[i] = (i < 32) ? '1 : t[34:0];
        end
        rom[7'h41] = 35'h4_0000_0001;
        rom[7'h20] = 35'h0;

        // model pins: hand-derived positions for the 0x41 stub and scan order
        get_pix(0, 0, 7'h41, r, c, on);
        chk("pin_first_on", on, 1);
        get_pix(0, 34, 7'h41, r, c, on);
        chk("pin_r6c4", {r, c, on}, {3'd6, 3'd4, 1'b1});
        ones = 0;
        for (int j = 0; j < 42; j++) begin
            get_pix(0, j, 7'h41, r, c, on);
            ones += int'(on);
        end
        chk("pin_ones", ones, 2);
        for (int j = 7; j < 14; j++) begin
            get_pix(0, j, 7'h41, r, c, on);
            chk($sformatf("pin_serp_row%0d", j), {c, r}, {3'd1, 3'(13 - j)});
            get_pix(1, j, 7'h41, r, c, on);
            chk($sformatf("pin_flat_row%0d", j), {c, r}, {3'd1, 3'(j - 7)});
        end
        get_pix(0, 41, 7'h41, r, c, on);
        chk("pin_last0", {r, c}, {3'd0, 3'd5});
        get_pix(1, 48, 7'h41, r, c, on);
        chk("pin_last1", {r, c}, {3'd6, 3'd6});

        // T1 reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_ready_in_rst", cif0.ready, 1);
        chk("t1_busy_in_rst", busy0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t1_ready", cif0.ready, 1);
        chk("t1_busy", busy0, 0);

        // T2 single glyph, latency and pixel count
        h0 = hs[0]; h1 = hs[1];
        @(posedge clk); #1 cv = 1'b1; code = 8'h41;
        @(negedge clk);
        chk("t2_accept", cif0.ready, 1);
        @(posedge clk); #1 cv = 1'b0;
        @(negedge clk);
        chk("t2_fetch_gap", pif0.valid, 0);
        chk("t2_addr", rom_addr0, 7'h41);
        @(negedge clk);
        chk("t2_first_valid", pif0.valid, 1);
        chk("t2_first_on", pif0.on, 1);
        wait_idle(200, "t2_idle");
        chk("t2_count0", hs[0] - h0, 42);
        chk("t2_count1", hs[1] - h1, 49);

        // T4 back-to-back
        @(posedge clk); #1 cv = 1'b1; code = 8'h48;
        wait_ready0(10, "t4_first");
        @(posedge clk); #1 code = 8'h49;
        wait_ready0(100, "t4_second");
        chk("t4_on_last", {pif0.valid, pif0.last}, 2'b11);
        @(posedge clk); #1 cv = 1'b0;
        @(negedge clk);
        chk("t4_gap", {pif0.valid, busy0}, 2'b01);
        @(negedge clk);
        chk("t4_restart", {pif0.valid, pif0.row, pif0.col, rom_addr0}, {1'b1, 3'd0, 3'd0, 7'h49});
        wait_idle(200, "t4_idle");

        // T5 backpressure + substitution
        h0 = hs[0];
        @(posedge clk); #1 cv = 1'b1; code = 8'hC1;
        @(posedge clk); #1 cv = 1'b0;
        @(negedge clk);
        chk("t5_subst", rom_addr0, 7'h3F);
        for (k = 0; k < 1000; k++) begin
            @(posedge clk); #1 pr = 1'($urandom_range(0, 1));
            if (m_phase[0] == 0 && m_phase[1] == 0) break;
        end
        pr = 1'b1;
        wait_idle(200, "t5_idle");
        chk("t5_count0", hs[0] - h0, 42);

        // T6 abort at pixel 10, then a blank glyph
        @(posedge clk); #1 cv = 1'b1; code = 8'h41;
        @(posedge clk); #1 cv = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (m_phase[0] == 2 && m_idx[0] == 9) break;
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        chk("t6_cleared", {pif0.valid, busy0}, 2'b00);
        @(posedge clk); #1 cv = 1'b1; code = 8'h20;
        @(posedge clk); #1 cv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_fresh", {pif0.valid, pif0.row, pif0.col, pif0.on}, {1'b1, 3'd0, 3'd0, 1'b0});
        wait_idle(200, "t6_idle");

        // async reset mid-glyph
        @(posedge clk); #1 cv = 1'b1; code = 8'h55;
        @(posedge clk); #1 cv = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy0, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            cv    = ($urandom_range(0, 2) == 0);
            code  = 8'($urandom);
            pr    = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 79) == 0);
        end
        cv = 1'b0; clear = 1'b0; pr = 1'b1;
        wait_idle(300, "rand_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
